my_mul_16_seq: RTL
==================

# my_mul_16_seq

Sequential 16×16 unsigned multiplier that time-shares a single `my_adder_16` instance over 16 shift-and-add cycles. The result is truncated to 16 bits to match the Hack-style ALU word. The block is the controller/sequencer around the adder: it captures operands, steps the adder once per cycle, and presents the result with a start/busy/done handshake. It sits beside the ALU as a multi-cycle functional unit.

## Interface
- Parameters: none. Datapath width is fixed at 16 by `my_adder_16`.
- `clk`  in  1  rising-edge clock, sole clock domain
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  request; sampled only when `busy`=0
- `a`  in  16  multiplicand; captured on accepted `start`
- `b`  in  16  multiplier; captured on accepted `start`
- `busy`  out  1  high while in RUN
- `done`  out  1  high in DONE; held until next accepted `start`
- `out`  out  16  low 16 bits of a×b; valid while `done`=1
- `ovf`  out  1  high product bits nonzero (only with `MY_MUL_OVF_EN`)

## Operation
- **Registers:**
  - `mcand[15:0]` holds `a`.
  - `hi[15:0]` holds the upper partial product.
  - `lo[15:0]` is initialised to `b`; it becomes the product low half.
  - `cnt[3:0]` counts steps.
  - `state`.
- **States and transitions:**
  - IDLE → RUN on `start`.
  - RUN → DONE when `cnt`=15 at the step edge.
  - DONE → RUN on `start`.
  - DONE stays DONE otherwise.
- **Accept:** in IDLE or DONE with `start`=1:
  - `mcand`←`a`, `hi`←0, `lo`←`b`, `cnt`←0.
  - `done`←0; state←RUN.
- **RUN step (one per cycle):**
  - The adder computes `sum = hi + (lo[0] ? mcand : 0)`.
  - Carry-out is reconstructed because `my_adder_16` drops it: `c = (x15&y15) | ((x15^y15) & ~sum15)`, where x and y are the adder inputs.
  - Update: `{hi,lo} ← {c, sum, lo} >> 1`, then `cnt ← cnt+1`.
- **Result:** after 16 steps, `lo` = (a×b) mod 2^16 and `hi` = (a×b) >> 16. `out` is driven from `lo`.
- **Ignored inputs:** `start` while `busy`=1 is ignored. Operand inputs are don't-care outside the accept cycle.
- **Arithmetic:** unsigned only, no sign handling. 0×anything yields 0 after the full 16 steps; there is no early exit.
- **Reset mid-operation:** aborts immediately; the step in flight is discarded.
- **Reset values (all outputs and registers):**
  - state=IDLE, `busy`=0, `done`=0, `out`=0, `ovf`=0.
  - `hi`, `lo`, `mcand`, `cnt` = 0.

## Timing
- `start` is accepted at edge E0.
- `busy`=1 from E0 through E16.
- Edges E1..E16 perform steps 0..15.
- At E16: `busy`→0, `done`→1, `out` valid. Latency is 16 cycles, start edge to done.
- Back-to-back operation: `start`=1 in the first DONE cycle is accepted at that edge. `done` drops at the same edge and `busy` rises. Throughput is one result per 17 cycles.
- `out` remains stable from E16 until the next accepted `start`. After the next accept it reflects the intermediate `lo` and is not meaningful while `busy`.
- `start` asserted on the cycle `reset_n` deasserts is not accepted. Reset wins.

## Configuration
- Macro: `MY_MUL_OVF_EN`.
- **Defined:**
  - Port `ovf` exists.
  - `ovf` = (`hi` != 0) registered at E16 and held with `done`.
  - `ovf` clears on accept and on reset.
- **Undefined:**
  - No `ovf` port.
  - `hi` is still required internally by the algorithm.
  - Timing and `out` are identical in both builds.

## Structure
- Shared package `my_mul_pkg`:
  - state enum `{IDLE, RUN, DONE}`.
  - `MUL_W`=16.
  - `MUL_LAST_STEP`=4'd15.
- One sub-module: the existing `my_adder_16`, instanced once as the step adder.
- Control logic and carry reconstruction live in `my_mul_16_seq`.

## Test plan
- Reset, then a=3, b=5, `start` one cycle → `busy` 16 cycles, then `done`=1, `out`=0x000F, `ovf`=0.
- a=0xFFFF, b=0xFFFF → `out`=0x0001, `ovf`=1 (exercises carry reconstruction every step).
- a=0x0100, b=0x0100 → `out`=0x0000, `ovf`=1; a=0x1234, b=0 → `out`=0x0000, `ovf`=0, still 16 cycles.
- Start a=7, b=9; pulse `start` with a=2, b=2 at step 5 → ignored; result `out`=0x003F.
- Deassert `reset_n` at step 8 of a=100, b=200 → next cycle `busy`=0, `done`=0, `out`=0; a fresh 10×10 gives 0x0064.
- In DONE, assert `start` with a=0x00FF, b=0x0101 → `done` drops the same edge, 16 cycles later `out`=0xFFFF, `ovf`=0.

Source files
------------

// File: rtl/my_mul_16_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier:
// state encoding, datapath width and the final step index.
package my_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned MUL_W = 16;
  localparam logic [3:0] MUL_LAST_STEP = 4'd15;

endpackage : my_mul_pkg

// File: rtl/my_mul_16_seq_if.sv
// Start/busy/done handshake and operand/result bus for my_mul_16_seq.
// The ovf signal exists only when MY_MUL_OVF_EN is defined.
interface my_mul_16_seq_if;
  import my_mul_pkg::*;

  logic             start;
  logic [MUL_W-1:0] a;
  logic [MUL_W-1:0] b;
  logic             busy;
  logic             done;
  logic [MUL_W-1:0] out;
`ifdef MY_MUL_OVF_EN
  logic             ovf;
`endif

  // Requester side: issues operands and start, observes status and result.
  modport master (
    output start, a, b,
`ifdef MY_MUL_OVF_EN
    input  ovf,
`endif
    input  busy, done, out
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
`ifdef MY_MUL_OVF_EN
    output ovf,
`endif
    output busy, done, out
  );

endinterface : my_mul_16_seq_if

// File: rtl/my_mul_16_seq_adder.sv
// my_adder_16: Hack-style 16-bit adder, carry-out discarded.
module my_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  // Plain modulo-2^16 sum.
  always_comb begin
    out = a + b;
  end

endmodule : my_adder_16

// File: rtl/my_mul_16_seq.sv
// my_mul_16_seq: sequential 16x16 unsigned shift-and-add multiplier built
// around a single my_adder_16. One step per cycle, 16 steps per product,
// low 16 bits of the product presented on out.
// Optional feature macro: MY_MUL_OVF_EN (adds the ovf output, set when the
// upper product half is nonzero).
module my_mul_16_seq
  import my_mul_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  my_mul_16_seq_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [MUL_W-1:0] mcand;
  logic [MUL_W-1:0] hi;
  logic [MUL_W-1:0] lo;
  logic [3:0]       cnt;

  logic             accept;
  logic             last_step;
  logic [MUL_W-1:0] adder_y;
  logic [MUL_W-1:0] sum;
  logic             carry;
  logic [MUL_W-1:0] hi_nxt;
  logic [MUL_W-1:0] lo_nxt;

  assign accept    = bus.start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == MUL_LAST_STEP);
  assign adder_y   = lo[0] ? mcand : '0;

  my_adder_16 u_step_adder (
    .a   (hi),
    .b   (adder_y),
    .out (sum)
  );

  // The adder drops its carry-out; rebuild it from the operand MSBs and the sum MSB.
  always_comb begin
    carry  = (hi[MUL_W-1] & adder_y[MUL_W-1]) |
             ((hi[MUL_W-1] ^ adder_y[MUL_W-1]) & ~sum[MUL_W-1]);
    hi_nxt = {carry, sum[MUL_W-1:1]};
    lo_nxt = {sum[0], lo[MUL_W-1:1]};
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept from IDLE/DONE, leave RUN after the last step.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on accept, one shift-and-add step per RUN cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= bus.a;
      hi    <= '0;
      lo    <= bus.b;
      cnt   <= '0;
    end else if (state == RUN) begin
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      cnt   <= cnt + 4'd1;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.out  = lo;

`ifdef MY_MUL_OVF_EN
  logic ovf_q;

  // Overflow flag: captured from the final upper half at the last step, held with done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last_step) begin
      ovf_q <= |hi_nxt;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule : my_mul_16_seq
